// File: rtl/mem_client_port_pkg.sv
// Shared constants for the client front end of the DDR controller:
// address field layout, default read latency and refresh interval.
package mem_client_port_pkg;

    localparam int ADDR_W = 27;
    localparam int DWIDTH = 32;

    localparam int ROW_HI  = 26;
    localparam int ROW_LO  = 15;
    localparam int BANK_HI = 14;
    localparam int BANK_LO = 13;
    localparam int COL_HI  = 12;

    localparam int READ_LAT_DEF       = 4;
    localparam int REFRESH_PERIOD_DEF = 1560;

    // Builds a client address from its row/bank/column fields.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [ROW_HI-ROW_LO:0]   row,
        input logic [BANK_HI-BANK_LO:0] bank,
        input logic [COL_HI:0]          col
    );
        return {row, bank, col};
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request queue in front of the controller: registered pointers and count,
// head entry presented combinationally from the read pointer.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_client_port.sv
// Client front end: queues requests toward the command-entry stage, returns
// read data with its tag after a fixed latency, and runs the refresh timer.
module mem_client_port
    import mem_client_port_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int READ_LAT       = READ_LAT_DEF,
    parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              REQ_WE,
    input  logic [DWIDTH-1:0] REQ_WDATA,
    input  logic [TAG_W-1:0]  REQ_TAG,
    output logic              RSP_VALID,
    output logic [DWIDTH-1:0] RSP_DATA,
    output logic [TAG_W-1:0]  RSP_TAG,
    output logic [ADDR_W-1:0] ADDRESS_REQ,
    output logic              WE,
    output logic [DWIDTH-1:0] DATA_W,
    output logic              DO_ACT,
    input  logic              COMMAND_LATCHED,
    input  logic [DWIDTH-1:0] DATA_R,
    output logic              REFRESH_STROBE
);

    localparam int ENT_W  = ADDR_W + 1 + DWIDTH + TAG_W;
    localparam int RCNT_W = $clog2(REFRESH_PERIOD);

    logic [ENT_W-1:0]  w_head;
    logic [TAG_W-1:0]  w_head_tag;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_issue;

    logic [READ_LAT:0] r_pipe_vld;
    logic [TAG_W-1:0]  r_pipe_tag [READ_LAT+1];
    logic              r_rsp_valid;
    logic [DWIDTH-1:0] r_rsp_data;
    logic [TAG_W-1:0]  r_rsp_tag;
    logic [RCNT_W-1:0] r_ref_cnt;
    logic              r_ref_strobe;

    // Ready is a pure function of the registered count; a pop in the same
    // cycle does not make room for a push.
    assign REQ_READY  = ~w_full;
    assign DO_ACT     = ~w_empty;
    assign w_push     = REQ_VALID & REQ_READY;
    assign w_pop      = DO_ACT & COMMAND_LATCHED;
    assign w_rd_issue = w_pop & ~WE;

    assign {ADDRESS_REQ, WE, DATA_W, w_head_tag} = w_head;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_wdata ({REQ_ADDR, REQ_WE, REQ_WDATA, REQ_TAG}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // One slot per cycle since the pop; the last stage lines up with the
    // cycle in which DATA_R carries that read's data.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pipe_vld  <= '0;
            for (int i = 0; i <= READ_LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
        end else begin
            r_pipe_vld    <= {r_pipe_vld[READ_LAT-1:0], w_rd_issue};
            r_pipe_tag[0] <= w_head_tag;
            for (int i = 1; i <= READ_LAT; i++) begin
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
            r_rsp_valid <= r_pipe_vld[READ_LAT];
            if (r_pipe_vld[READ_LAT]) begin
                r_rsp_data <= DATA_R;
                r_rsp_tag  <= r_pipe_tag[READ_LAT];
            end
        end
    end

    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_TAG   = r_rsp_tag;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ref_cnt    <= '0;
            r_ref_strobe <= 1'b0;
        end else if (r_ref_cnt == RCNT_W'(REFRESH_PERIOD - 1)) begin
            r_ref_cnt    <= '0;
            r_ref_strobe <= ~r_ref_strobe;
        end else begin
            r_ref_cnt    <= r_ref_cnt + 1'b1;
        end
    end

    assign REFRESH_STROBE = r_ref_strobe;

endmodule

// File: doc/mem_client_port.md
Name: mem_client_port

Overview:
- Client-facing front end of the DDR SDRAM controller; sits directly upstream of the command-entry stage.
- Queues client read/write requests and presents the head request as ADDRESS_REQ/WE/DATA_W with DO_ACT.
- Pops the head on COMMAND_LATCHED, and times read-data return from DATA_R, returning it with the request tag.
- Owns the periodic refresh timer; the timer drives the toggle-style REFRESH_STROBE.

Parameters:
- DEPTH, 4: request FIFO entries. Power of two, minimum 2.
- TAG_W, 4: width of the client request tag.
- READ_LAT, 4: cycles from the COMMAND_LATCHED sample until DATA_R is valid.
- REFRESH_PERIOD, 1560: CLK cycles between refresh strobe toggles (7.8 us at 200 MHz).

Ports:
- CLK  in  1  system clock. All logic is on the rising edge.
- RST  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  client request valid.
- REQ_READY  out  1  FIFO can accept a request.
- REQ_ADDR  in  27  client address: row [26:15], bank [14:13], column [12:0].
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_WDATA  in  32  write data.
- REQ_TAG  in  TAG_W  client tag, echoed back with read data.
- RSP_VALID  out  1  read data valid; single-cycle pulse.
- RSP_DATA  out  32  read data.
- RSP_TAG  out  TAG_W  tag of the returned read.
- ADDRESS_REQ  out  27  head address, to the controller.
- WE  out  1  head write flag.
- DATA_W  out  32  head write data.
- DO_ACT  out  1  head valid, to the controller.
- COMMAND_LATCHED  in  1  controller accepted the head.
- DATA_R  in  32  controller read data.
- REFRESH_STROBE  out  1  toggles once per refresh request.

Behaviour:
- Reset (RST=0 at an edge):
  - FIFO emptied; REQ_READY=1 from the next cycle.
  - DO_ACT=0, RSP_VALID=0, RSP_DATA=0, RSP_TAG=0.
  - Read-tracking pipeline cleared; REFRESH_STROBE=0; refresh counter=0.
  - Reset mid-operation drops queued requests and in-flight reads. No RSP is produced for them.
- FIFO:
  - Entry = {addr, we, wdata, tag}. Registered count and pointers; pointers wrap modulo DEPTH.
  - REQ_READY = (count != DEPTH). It is not combinationally dependent on pop, so a full FIFO refuses a push even in a pop cycle.
  - Push occurs on REQ_VALID & REQ_READY.
  - Pop occurs on DO_ACT & COMMAND_LATCHED.
  - Simultaneous push and pop leaves count unchanged.
  - DO_ACT = (count != 0). ADDRESS_REQ, WE and DATA_W are muxed from the head entry and stay stable until popped.
  - After a pop, the next entry (if any) is presented in the following cycle with DO_ACT held high, giving back-to-back presentation.
  - COMMAND_LATCHED while DO_ACT=0 is ignored.
- Read return:
  - A pop of a read entry at edge t inserts {1, tag} into a valid/tag shift pipeline of READ_LAT+1 stages.
  - At edge t+READ_LAT+1, RSP_DATA<=DATA_R and RSP_TAG<=tag, and RSP_VALID=1 for exactly one cycle.
  - Write pops insert a bubble and never produce RSP.
  - There is no response back-pressure; the client must accept RSP every cycle.
  - Multiple reads in flight are supported, one per stage, and return in order.
- Refresh:
  - The counter increments every cycle.
  - When it reaches REFRESH_PERIOD-1, it wraps to 0 and REFRESH_STROBE inverts on that edge.
  - The counter is free-running and independent of request traffic. The controller's ack register absorbs the toggle.

Decomposition:
- Shared package holds:
  - address field constants: ROW_HI=26, ROW_LO=15, BANK_HI=14, BANK_LO=13, COL_HI=12;
  - READ_LAT default;
  - REFRESH_PERIOD default.
- Natural sub-module: mem_req_fifo.
  - Parameterised DEPTH and width; provides push/pop, count, full/empty, and head data out.
- The read-tracking pipeline and the refresh timer stay in mem_client_port.

Test Plan:
1. Reset, then idle 3125 cycles → REFRESH_STROBE toggles at edges 1560 and 3120 after reset release; DO_ACT=0 and RSP_VALID=0 throughout.
2. Single write (addr 0x0012345, wdata 0xDEADBEEF, tag 3); controller raises COMMAND_LATCHED 6 cycles after DO_ACT → ADDRESS_REQ/DATA_W stable all 6 cycles; DO_ACT drops the next cycle; no RSP.
3. Single read (tag 5) latched at edge t; bench drives DATA_R=0xCAFEF00D only in the cycle after edge t+4 → RSP_VALID=1, RSP_DATA=0xCAFEF00D, RSP_TAG=5 after edge t+5, for one cycle only.
4. Push 5 requests back-to-back with no COMMAND_LATCHED, DEPTH=4 → REQ_READY=0 after the 4th; 5th held off; one pop → the 5th accepted the following cycle; order preserved.
5. Reads tags 1 and 2 latched on consecutive edges → two RSP pulses on consecutive cycles, tags 1 then 2, with matching data.
6. Reset asserted one cycle after a read is latched → no RSP_VALID ever; FIFO empty; REFRESH_STROBE=0; refresh period restarts from 0.
